// File: rtl/frame_max_pkg.sv
// Shared definitions for the frame_max block: FSM state encoding and
// default datapath widths. Optional minimum tracking is enabled by
// defining FRAME_MAX_MIN_EN.
package frame_max_pkg;

    // Default sample/result width and sample-counter width.
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 8;

    // Frame FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no frame open
        ACC  = 2'd1,   // frame open, accumulating
        HOLD = 2'd2    // result presented, waiting for consumer
    } state_t;

endpackage

// File: rtl/frame_max_if.sv
// Handshake bundle for frame_max: sample input stream and result output.
// out_min exists only when FRAME_MAX_MIN_EN is defined.
interface frame_max_if
    import frame_max_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_max;
    logic [CW-1:0] out_count;
`ifdef FRAME_MAX_MIN_EN
    logic [DW-1:0] out_min;
`endif

    // Producer/consumer side (drives samples, takes results).
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_count
`ifdef FRAME_MAX_MIN_EN
        , input out_min
`endif
    );

    // Block side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_count
`ifdef FRAME_MAX_MIN_EN
        , output out_min
`endif
    );
endinterface

// File: rtl/frame_max_cmp_sel.sv
// Combinational unsigned two-input select: returns the larger input when
// PICK_MAX=1, the smaller otherwise. On equal inputs both are the same
// value, so ties leave the running extreme unchanged.
module cmp_sel #(
    parameter int DW       = 8,
    parameter bit PICK_MAX = 1'b1
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    // Unsigned compare and select.
    always_comb begin
        if (PICK_MAX) y = (b > a) ? b : a;
        else          y = (b < a) ? b : a;
    end
endmodule

// File: rtl/frame_max.sv
// frame_max: tracks the largest unsigned sample and the saturating sample
// count of each frame, presenting the result for one handshake.
// Optional: FRAME_MAX_MIN_EN adds out_min (smallest sample of the frame).
module frame_max
    import frame_max_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    frame_max_if.slave  bus
);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_SAT = '1;

    state_t        state_q, state_d;
    logic          in_ready, out_valid, accept;
    logic [DW-1:0] max_q, max_sel;
    logic [CW-1:0] count_q;

    assign accept = bus.in_valid & in_ready;

    cmp_sel #(.DW(DW), .PICK_MAX(1'b1)) u_max_sel (
        .a (max_q),
        .b (bus.in_data),
        .y (max_sel)
    );

`ifdef FRAME_MAX_MIN_EN
    logic [DW-1:0] min_q, min_sel;

    cmp_sel #(.DW(DW), .PICK_MAX(1'b0)) u_min_sel (
        .a (min_q),
        .b (bus.in_data),
        .y (min_sel)
    );

    // Running minimum: seeded by the first sample, then the smaller kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      min_q <= '0;
        else if (accept && state_q == IDLE) min_q <= bus.in_data;
        else if (accept)                 min_q <= min_sel;
    end

    assign bus.out_min = min_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.in_last ? HOLD : ACC;
            ACC:     if (accept && bus.in_last) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: accept input except while a result is held.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_q)
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Running maximum and saturating count; both hold between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q   <= '0;
            count_q <= '0;
        end else if (accept && state_q == IDLE) begin
            max_q   <= bus.in_data;
            count_q <= CNT_ONE;
        end else if (accept) begin
            max_q   <= max_sel;
            count_q <= (count_q == CNT_SAT) ? count_q : count_q + CNT_ONE;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_max   = max_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_frame_max.sv
// Directed self-checking bench for frame_max. A default-width instance
// covers the main behaviour; a CW=4 instance covers count saturation.
module tb_frame_max;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    frame_max_if #(.DW(8), .CW(8)) a ();
    frame_max_if #(.DW(8), .CW(4)) b ();

    frame_max #(.DW(8), .CW(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(a));
    frame_max #(.DW(8), .CW(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic l);
        a.in_valid = 1'b1; a.in_data = d; a.in_last = l;
        tick();
        a.in_valid = 1'b0; a.in_last = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic l);
        b.in_valid = 1'b1; b.in_data = d; b.in_last = l;
        tick();
        b.in_valid = 1'b0; b.in_last = 1'b0;
    endtask

    task automatic drain_a();
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
    endtask

    initial begin
        a.in_valid = 0; a.in_data = 0; a.in_last = 0; a.out_ready = 0;
        b.in_valid = 0; b.in_data = 0; b.in_last = 0; b.out_ready = 0;

        // Reset state, observed before any clock edge.
        #1;
        check("rst_in_ready",  a.in_ready, 1);
        check("rst_out_valid", a.out_valid, 0);
        check("rst_out_max",   a.out_max, 0);
        check("rst_out_count", a.out_count, 0);
        check("rst4_out_count", b.out_count, 0);
`ifdef FRAME_MAX_MIN_EN
        check("rst_out_min", a.out_min, 0);
`endif
        #2 rst_n = 1'b1;
        tick();

        // Frame 3,9,9,2: max 9 with a tie, count 4, valid one cycle after last.
        send_a(8'd3, 0);
        check("f1_mid_valid", a.out_valid, 0);
        check("f1_mid_ready", a.in_ready, 1);
        send_a(8'd9, 0);
        send_a(8'd9, 0);
        send_a(8'd2, 1);
        check("f1_valid", a.out_valid, 1);
        check("f1_max",   a.out_max, 9);
        check("f1_count", a.out_count, 4);
        check("f1_in_ready_hold", a.in_ready, 0);
        drain_a();
        check("f1_idle_valid", a.out_valid, 0);
        check("f1_idle_ready", a.in_ready, 1);
        check("f1_idle_max_held", a.out_max, 9);

        // Single-sample frame 0xA5.
        send_a(8'hA5, 1);
        check("f2_valid", a.out_valid, 1);
        check("f2_max",   a.out_max, 8'hA5);
        check("f2_count", a.out_count, 1);
        drain_a();

        // Result 0x40 held for 5 cycles while a new sample is offered.
        send_a(8'h40, 1);
        a.in_valid = 1; a.in_data = 8'h77; a.in_last = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("f3_hold_ready", a.in_ready, 0);
            check("f3_hold_valid", a.out_valid, 1);
            check("f3_hold_max",   a.out_max, 8'h40);
            check("f3_hold_count", a.out_count, 1);
        end
        a.out_ready = 1;
        tick();
        a.out_ready = 0;
        check("f3_idle_valid", a.out_valid, 0);
        check("f3_nobypass_max", a.out_max, 8'h40);
        tick();
        a.in_valid = 0; a.in_last = 0;
        check("f4_valid", a.out_valid, 1);
        check("f4_max",   a.out_max, 8'h77);
        check("f4_count", a.out_count, 1);
        drain_a();

        // in_last without in_valid is ignored.
        a.in_data = 8'hEE; a.in_last = 1;
        tick();
        a.in_last = 0;
        check("nv_valid", a.out_valid, 0);
        check("nv_ready", a.in_ready, 1);

        // Larger first sample is kept.
        send_a(8'h80, 0);
        send_a(8'h20, 1);
        check("f5_max",   a.out_max, 8'h80);
        check("f5_count", a.out_count, 2);
        drain_a();

`ifdef FRAME_MAX_MIN_EN
        // Minimum tracking: frame 7,0,200.
        send_a(8'd7, 0);
        send_a(8'd0, 0);
        send_a(8'd200, 1);
        check("fm_max",   a.out_max, 200);
        check("fm_min",   a.out_min, 0);
        check("fm_count", a.out_count, 3);
        drain_a();
`endif

        // Reset mid-frame discards the partial frame.
        send_a(8'hFF, 0);
        send_a(8'h10, 0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", a.out_valid, 0);
        check("mr_max",   a.out_max, 0);
        check("mr_count", a.out_count, 0);
        check("mr_ready", a.in_ready, 1);
        #1 rst_n = 1'b1;
        tick();
        send_a(8'h05, 1);
        check("mr_f_valid", a.out_valid, 1);
        check("mr_f_max",   a.out_max, 8'h05);
        check("mr_f_count", a.out_count, 1);
        drain_a();

        // CW=4 instance: 20 samples of 0x01 saturate the count at 15.
        for (int i = 0; i < 20; i++) send_b(8'h01, i == 19);
        check("sat_valid", b.out_valid, 1);
        check("sat_count", b.out_count, 15);
        check("sat_max",   b.out_max, 8'h01);
        b.out_ready = 1;
        tick();
        b.out_ready = 0;
        check("sat_idle_valid", b.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
